// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores on a req/ack data bus, stalls upstream while busy,
// and holds the M/W pipeline register. Optional watchdog: define MEM_STAGE_TIMEOUT_EN.
module mem_stage #(
  parameter int DBITS       = 32,
  parameter int REGNO       = 4,
  parameter int WADDR_BITS  = 13,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DBITS-1:0]      incPC_M,
  input  logic [DBITS-1:0]      ALUresult_M,
  input  logic [DBITS-1:0]      src2Data_M,
  input  logic [REGNO-1:0]      destIndex_M,
  input  logic                  memWrtEn_M,
  input  logic [1:0]            regFileMux_M,
  input  logic                  regWrtEn_M,
  input  logic                  noop_M,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [WADDR_BITS-1:0] mem_addr,
  output logic [DBITS-1:0]      mem_wdata,
  input  logic                  mem_ack,
  input  logic [DBITS-1:0]      mem_rdata,
  output logic                  stall_M,
  output logic [DBITS-1:0]      regWrtData_W,
  output logic [REGNO-1:0]      destIndex_W,
  output logic                  regWrtEn_W,
  output logic                  noop_W,
  output logic [15:0]           stall_cnt,
  output logic                  mem_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state_reg, state_next;
  logic                    mem_req_reg;
  logic                    mem_we_reg;
  logic [WADDR_BITS-1:0]   mem_addr_reg;
  logic [DBITS-1:0]        mem_wdata_reg;
  logic [DBITS-1:0]        wb_data_reg;
  logic [REGNO-1:0]        wb_dest_reg;
  logic                    wb_en_reg;
  logic                    wb_noop_reg;
  logic [15:0]             stall_cnt_reg;
  logic                    memop;
  logic                    timeout_hit;
  logic [DBITS-1:0]        wb_data_next;

  assign memop = !noop_M && (memWrtEn_M || (regFileMux_M == 2'b01));

`ifdef MEM_STAGE_TIMEOUT_EN
  logic [7:0] wd_cnt_reg;
  logic       mem_err_reg;

  // Abort fires on the TIMEOUT_CYC-th ACCESS cycle; the instruction then retires like an ack.
  assign timeout_hit = (state_reg == ACCESS) && !mem_ack &&
                       (wd_cnt_reg == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_reg  <= 8'd0;
      mem_err_reg <= 1'b0;
    end else begin
      if (state_reg == ACCESS && state_next == ACCESS)
        wd_cnt_reg <= wd_cnt_reg + 8'd1;
      else
        wd_cnt_reg <= 8'd0;
      if (timeout_hit)
        mem_err_reg <= 1'b1;
    end
  end

  assign mem_err = mem_err_reg;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYC != 0);
  assign timeout_hit    = 1'b0;
  assign mem_err        = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    stall_M    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (memop) begin
          state_next = ACCESS;
          stall_M    = 1'b1;
        end
      end
      ACCESS: begin
        if (mem_ack || timeout_hit)
          state_next = IDLE;
        else
          stall_M = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    // Upstream must not see a stall while the stage is being reset.
    if (reset)
      stall_M = 1'b0;
  end

  always_comb begin
    wb_data_next = ALUresult_M;
    case (regFileMux_M)
      2'b01:   wb_data_next = timeout_hit ? DBITS'(32'hDEADBEEF) : mem_rdata;
      2'b10:   wb_data_next = incPC_M;
      default: wb_data_next = ALUresult_M;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg   <= state_next;
      mem_req_reg <= (state_next == ACCESS);
      // Bus fields are captured once on entry and held for the whole access.
      if (state_reg == IDLE && memop) begin
        mem_we_reg    <= memWrtEn_M;
        mem_addr_reg  <= ALUresult_M[WADDR_BITS+1:2];
        mem_wdata_reg <= src2Data_M;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_data_reg   <= '0;
      wb_dest_reg   <= '0;
      wb_en_reg     <= 1'b0;
      wb_noop_reg   <= 1'b1;
      stall_cnt_reg <= 16'd0;
    end else begin
      if (!stall_M) begin
        wb_data_reg <= wb_data_next;
        wb_dest_reg <= destIndex_M;
        wb_en_reg   <= regWrtEn_M && !noop_M;
        wb_noop_reg <= noop_M;
      end else begin
        wb_en_reg   <= 1'b0;
        wb_noop_reg <= 1'b1;
      end
      if (stall_M && stall_cnt_reg != 16'hFFFF)
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign mem_req      = mem_req_reg;
  assign mem_we       = mem_we_reg;
  assign mem_addr     = mem_addr_reg;
  assign mem_wdata    = mem_wdata_reg;
  assign regWrtData_W = wb_data_reg;
  assign destIndex_W  = wb_dest_reg;
  assign regWrtEn_W   = wb_en_reg;
  assign noop_W       = wb_noop_reg;
  assign stall_cnt    = stall_cnt_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU, incPC, load, store, noop, reset mid-access,
// and (with MEM_STAGE_TIMEOUT_EN) the watchdog abort.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] incPC_M, ALUresult_M, src2Data_M;
  logic [3:0]  destIndex_M;
  logic        memWrtEn_M;
  logic [1:0]  regFileMux_M;
  logic        regWrtEn_M, noop_M;
  logic        mem_req, mem_we;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_M;
  logic [31:0] regWrtData_W;
  logic [3:0]  destIndex_W;
  logic        regWrtEn_W, noop_W;
  logic [15:0] stall_cnt;
  logic        mem_err;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mem_stage #(.DBITS(32), .REGNO(4), .WADDR_BITS(13), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset),
    .incPC_M(incPC_M), .ALUresult_M(ALUresult_M), .src2Data_M(src2Data_M),
    .destIndex_M(destIndex_M), .memWrtEn_M(memWrtEn_M), .regFileMux_M(regFileMux_M),
    .regWrtEn_M(regWrtEn_M), .noop_M(noop_M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall_M(stall_M),
    .regWrtData_W(regWrtData_W), .destIndex_W(destIndex_W), .regWrtEn_W(regWrtEn_W),
    .noop_W(noop_W), .stall_cnt(stall_cnt), .mem_err(mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    noop_M = 1'b1; memWrtEn_M = 1'b0; regFileMux_M = 2'b00; regWrtEn_M = 1'b0;
    destIndex_M = 4'd0; ALUresult_M = 32'd0; src2Data_M = 32'd0; incPC_M = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] alu, input logic [1:0] mux, input logic wen,
                        input logic [3:0] dest, input logic st, input logic [31:0] sdata);
    noop_M = 1'b0; ALUresult_M = alu; regFileMux_M = mux; regWrtEn_M = wen;
    destIndex_M = dest; memWrtEn_M = st; src2Data_M = sdata;
  endtask

  int stalls;
  int wen_pulses;

  initial begin
    idle_inputs();
    reset = 1'b1;
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_stall", stall_M, 0);
    chk("rst_noop_W", noop_W, 1);
    chk("rst_wen_W", regWrtEn_W, 0);
    chk("rst_data_W", regWrtData_W, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_mem_err", mem_err, 0);
    $display("reset: values checked");
    @(negedge clk);
    reset = 1'b0;
    tick();

    // ALU op
    set_op(32'h1234, 2'b00, 1'b1, 4'd5, 1'b0, 32'd0);
    #1;
    chk("alu_stall", stall_M, 0);
    tick();
    chk("alu_data", regWrtData_W, 32'h1234);
    chk("alu_dest", destIndex_W, 5);
    chk("alu_wen", regWrtEn_W, 1);
    chk("alu_noop_W", noop_W, 0);
    $display("alu: data=%h dest=%0d", regWrtData_W, destIndex_W);

    // incPC op, reserved mux code 11 falls back to ALU
    set_op(32'h55, 2'b10, 1'b1, 4'd3, 1'b0, 32'd0);
    incPC_M = 32'h100;
    tick();
    chk("incpc_data", regWrtData_W, 32'h100);
    set_op(32'h77, 2'b11, 1'b1, 4'd4, 1'b0, 32'd0);
    tick();
    chk("mux11_data", regWrtData_W, 32'h77);
    $display("incpc/mux11: data=%h", regWrtData_W);
    idle_inputs();
    tick();

    // Load from 0x40, three waiting ACCESS cycles then ack
    set_op(32'h40, 2'b01, 1'b1, 4'd7, 1'b0, 32'd0);
    stalls = 0;
    wen_pulses = 0;
    repeat (4) begin
      #1;
      if (stall_M) stalls++;
      @(posedge clk);
      #1;
      if (regWrtEn_W) wen_pulses++;
    end
    chk("ld_mem_req", mem_req, 1);
    chk("ld_mem_addr", mem_addr, 32'h10);
    chk("ld_mem_we", mem_we, 0);
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    #1;
    chk("ld_ack_stall", stall_M, 0);
    tick();
    idle_inputs();
    if (regWrtEn_W) wen_pulses++;
    chk("ld_stalls", stalls, 4);
    chk("ld_data", regWrtData_W, 32'hCAFEF00D);
    chk("ld_dest", destIndex_W, 7);
    chk("ld_req_drop", mem_req, 0);
    chk("ld_stall_cnt", stall_cnt, 4);
    tick();
    if (regWrtEn_W) wen_pulses++;
    chk("ld_wen_pulses", wen_pulses, 1);
    $display("load: data=%h stalls=%0d pulses=%0d", regWrtData_W, stalls, wen_pulses);

    // Store to 0x8, ack on first ACCESS cycle
    set_op(32'h8, 2'b00, 1'b0, 4'd2, 1'b1, 32'hA5A5A5A5);
    #1;
    chk("st_stall_idle", stall_M, 1);
    tick();
    chk("st_mem_req", mem_req, 1);
    chk("st_mem_we", mem_we, 1);
    chk("st_mem_addr", mem_addr, 32'h2);
    chk("st_mem_wdata", mem_wdata, 32'hA5A5A5A5);
    mem_ack = 1'b1;
    #1;
    chk("st_ack_stall", stall_M, 0);
    tick();
    idle_inputs();
    chk("st_req_drop", mem_req, 0);
    chk("st_wen", regWrtEn_W, 0);
    chk("st_noop_W", noop_W, 0);
    chk("st_stall_cnt", stall_cnt, 5);
    $display("store: addr=%h wdata=%h", mem_addr, mem_wdata);

    // Bubble carrying memWrtEn must not touch memory
    noop_M = 1'b1; memWrtEn_M = 1'b1; regFileMux_M = 2'b01; regWrtEn_M = 1'b1;
    #1;
    chk("noop_stall", stall_M, 0);
    tick();
    chk("noop_noop_W", noop_W, 1);
    chk("noop_wen", regWrtEn_W, 0);
    tick();
    chk("noop_mem_req", mem_req, 0);
    // ack in IDLE is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_req", mem_req, 0);
    chk("idle_ack_cnt", stall_cnt, 5);
    $display("noop: mem_req=%b noop_W=%b", mem_req, noop_W);
    idle_inputs();

    // Reset asserted between edges while in ACCESS
    set_op(32'h80, 2'b01, 1'b1, 4'd9, 1'b0, 32'd0);
    tick();
    chk("rmid_in_access", mem_req, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rmid_req", mem_req, 0);
    chk("rmid_stall", stall_M, 0);
    chk("rmid_noop_W", noop_W, 1);
    chk("rmid_stall_cnt", stall_cnt, 0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h1111;
    tick();
    mem_ack = 1'b0;
    chk("rmid_late_ack_req", mem_req, 0);
    chk("rmid_late_ack_wen", regWrtEn_W, 0);
    $display("reset-mid-access: mem_req=%b stall_cnt=%0d", mem_req, stall_cnt);

`ifdef MEM_STAGE_TIMEOUT_EN
    // Load never acked: aborts on the 8th ACCESS cycle
    set_op(32'h44, 2'b01, 1'b1, 4'd6, 1'b0, 32'd0);
    tick();
    repeat (7) tick();
    chk("to_abort_stall", stall_M, 0);
    tick();
    idle_inputs();
    chk("to_req", mem_req, 0);
    chk("to_err", mem_err, 1);
    chk("to_data", regWrtData_W, 32'hDEADBEEF);
    chk("to_wen", regWrtEn_W, 1);
    tick();
    chk("to_err_sticky", mem_err, 1);
    $display("timeout: mem_err=%b data=%h", mem_err, regWrtData_W);
`else
    chk("no_to_err", mem_err, 0);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
